// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 @ 60 Hz VGA timing constants.
// Every renderer imports this package so coordinate arithmetic agrees with
// the sync generator. Holds the visible/porch/sync widths, the derived
// totals and sync windows, and the 10-bit coordinate type.
package vga_pkg;
  localparam int CW = 10;
  typedef logic [CW-1:0] coord_t;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOT      = H_VIS + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOT      = V_VIS + V_FP + V_SYNC + V_BP;  // 525
  localparam int H_SYNC_INI = H_VIS + H_FP;                  // 656
  localparam int H_SYNC_FIM = H_SYNC_INI + H_SYNC - 1;       // 751
  localparam int V_SYNC_INI = V_VIS + V_FP;                  // 490
  localparam int V_SYNC_FIM = V_SYNC_INI + V_SYNC - 1;       // 491

  localparam int DIV_DEF = 2;  // 50 MHz clk -> 25 MHz pixel
endpackage

// File: rtl/vga_contador_eixo.sv
// vga_contador_eixo: one VGA axis counter (used for both columns and lines).
// Ports:
//   clk, reset  - system clock, async active-high reset
//   en          - advance the count this cycle
//   count       - current position 0..TOTAL-1
//   wrap        - count is at TOTAL-1 (carry out, combinational)
//   sync_n      - registered active-low sync, aligned with count
//   ativo       - visible-region decode of the value count holds after this
//                 cycle (lookahead, lets the top register areaAtiva in step)
module vga_contador_eixo
  import vga_pkg::*;
#(
  parameter int TOTAL    = H_TOT,
  parameter int VIS      = H_VIS,
  parameter int SYNC_INI = H_SYNC_INI,
  parameter int SYNC_FIM = H_SYNC_FIM
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_n,
  output logic          ativo
);
  localparam coord_t LAST  = coord_t'(TOTAL - 1);
  localparam coord_t VIS_C = coord_t'(VIS);
  localparam coord_t S_INI = coord_t'(SYNC_INI);
  localparam coord_t S_FIM = coord_t'(SYNC_FIM);

  coord_t nxt;

  assign wrap = (count == LAST);

  always_comb begin
    nxt = wrap ? '0 : count + coord_t'(1);
  end

  // Lookahead so the registered areaAtiva changes on the same edge as count.
  assign ativo = en ? (nxt < VIS_C) : (count < VIS_C);

  // Sync is decoded from the next value and registered, so it is
  // glitch-free and edge-aligned with count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      sync_n <= 1'b1;
    end else if (en) begin
      count  <= nxt;
      sync_n <= !((nxt >= S_INI) && (nxt <= S_FIM));
    end
  end
endmodule

// File: rtl/vga_sincronizador.sv
// vga_sincronizador: VGA timing generator (default 640x480 @ 60 Hz).
// Divides clk by DIV to the pixel rate and drives the column/line counters.
// Ports:
//   clk, reset    - system clock, async active-high reset
//   coluna, linha - pixel / line coordinates
//   areaAtiva     - high while (coluna, linha) is in the visible region
//   hsync, vsync  - active-low monitor syncs
//   pixelTick     - one-clk pulse on the first clk of each new coordinate
//   inicioQuadro  - one-clk pulse when the counters wrap to (0,0)
// All outputs are registers and change on the same clk edge.
module vga_sincronizador #(
  parameter int DIV    = vga_pkg::DIV_DEF,
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] coluna,
  output logic [9:0] linha,
  output logic       areaAtiva,
  output logic       hsync,
  output logic       vsync,
  output logic       pixelTick,
  output logic       inicioQuadro
);
  import vga_pkg::*;

  localparam int H_TOT_P = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT_P = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  logic [3:0] div_cnt;
  logic       tick;
  logic       h_wrap, v_wrap;
  logic       h_ativo, v_ativo;

  // With DIV = 1 div_cnt stays 0 and tick is constantly 1.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 4'd1;
  end

  vga_contador_eixo #(
    .TOTAL(H_TOT_P), .VIS(H_VIS),
    .SYNC_INI(H_VIS + H_FP), .SYNC_FIM(H_VIS + H_FP + H_SYNC - 1)
  ) u_h (
    .clk(clk), .reset(reset), .en(tick),
    .count(coluna), .wrap(h_wrap), .sync_n(hsync), .ativo(h_ativo)
  );

  // Lines advance only on the tick that wraps the column counter.
  vga_contador_eixo #(
    .TOTAL(V_TOT_P), .VIS(V_VIS),
    .SYNC_INI(V_VIS + V_FP), .SYNC_FIM(V_VIS + V_FP + V_SYNC - 1)
  ) u_v (
    .clk(clk), .reset(reset), .en(h_wrap & tick),
    .count(linha), .wrap(v_wrap), .sync_n(vsync), .ativo(v_ativo)
  );

  // Reset lands on (0,0), which is visible, hence areaAtiva resets to 1.
  // inicioQuadro only fires on a real wrap, never for the reset origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      areaAtiva    <= 1'b1;
      pixelTick    <= 1'b0;
      inicioQuadro <= 1'b0;
    end else begin
      areaAtiva    <= h_ativo & v_ativo;
      pixelTick    <= tick;
      inicioQuadro <= tick & h_wrap & v_wrap;
    end
  end
endmodule

// File: tb/tb_vga_sincronizador.sv
// Scoreboard bench: three DUTs (small geometry DIV=2, small geometry DIV=1,
// full 640x480 geometry DIV=2) share clk/reset. A reference process derives
// the expected outputs from the number of clk edges since reset release
// (ticks = edges/DIV, position = ticks mod frame) and queues them; a monitor
// pops and compares on the falling edge. Reset is asserted at random
// mid-cycle points and checked immediately, without a clock edge.
module tb_vga_sincronizador;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][9:0] col, lin;
  logic [2:0]      hs, vs, aa, pt, iq;

  int checks = 0;
  int errors = 0;

  // DIV, H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP
  int cfg [3][9] = '{'{2, 20, 3, 5, 4, 6, 2, 2, 3},
                     '{1, 20, 3, 5, 4, 6, 2, 2, 3},
                     '{2, 640, 16, 96, 48, 480, 10, 2, 33}};

  vga_sincronizador #(.DIV(2), .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) u0 (
    .clk(clk), .reset(reset), .coluna(col[0]), .linha(lin[0]),
    .areaAtiva(aa[0]), .hsync(hs[0]), .vsync(vs[0]),
    .pixelTick(pt[0]), .inicioQuadro(iq[0]));

  vga_sincronizador #(.DIV(1), .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) u1 (
    .clk(clk), .reset(reset), .coluna(col[1]), .linha(lin[1]),
    .areaAtiva(aa[1]), .hsync(hs[1]), .vsync(vs[1]),
    .pixelTick(pt[1]), .inicioQuadro(iq[1]));

  vga_sincronizador #(.DIV(2)) u2 (
    .clk(clk), .reset(reset), .coluna(col[2]), .linha(lin[2]),
    .areaAtiva(aa[2]), .hsync(hs[2]), .vsync(vs[2]),
    .pixelTick(pt[2]), .inicioQuadro(iq[2]));

  function automatic logic [24:0] obs(int k);
    return {col[k], lin[k], hs[k], vs[k], aa[k], pt[k], iq[k]};
  endfunction

  // Expected outputs after e clk edges since reset release.
  function automatic logic [24:0] ref_out(int e, int k);
    int div, hv, hfp, hsw, vv, vfp, vsw, htot, vtot, n, p, c, l;
    logic h, v, a, ptk, iqk;
    div = cfg[k][0];
    hv = cfg[k][1]; hfp = cfg[k][2]; hsw = cfg[k][3];
    vv = cfg[k][5]; vfp = cfg[k][6]; vsw = cfg[k][7];
    htot = hv + hfp + hsw + cfg[k][4];
    vtot = vv + vfp + vsw + cfg[k][8];
    n = e / div;
    p = n % (htot * vtot);
    c = p % htot;
    l = p / htot;
    h = !(c >= hv + hfp && c < hv + hfp + hsw);
    v = !(l >= vv + vfp && l < vv + vfp + vsw);
    a = (c < hv) && (l < vv);
    ptk = (e > 0) && (e % div == 0);
    iqk = ptk && (p == 0);
    return {10'(c), 10'(l), h, v, a, ptk, iqk};
  endfunction

  task automatic report(string name, int k, logic [24:0] got, logic [24:0] want);
    $display("FAIL %s dut%0d t=%0t got col=%0d lin=%0d hs=%b vs=%b aa=%b pt=%b iq=%b want col=%0d lin=%0d hs=%b vs=%b aa=%b pt=%b iq=%b",
             name, k, $time, got[24:15], got[14:5], got[4], got[3], got[2], got[1], got[0],
             want[24:15], want[14:5], want[4], want[3], want[2], want[1], want[0]);
  endtask

  typedef logic [2:0][24:0] trip_t;
  trip_t q[$];

  // Reference model: counts clk edges since reset release.
  initial begin
    int e;
    trip_t t;
    e = 0;
    forever begin
      @(posedge clk);
      if (reset) e = 0;
      else       e++;
      for (int k = 0; k < 3; k++) t[k] = ref_out(e, k);
      q.push_back(t);
    end
  end

  // Monitor: compares every DUT output on the falling edge.
  initial begin
    trip_t w;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty t=%0t got 0 entries want 1", $time);
      end else begin
        w = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs(k) !== w[k]) begin
            errors++;
            report("timing", k, obs(k), w[k]);
          end
        end
      end
    end
  end

  localparam logic [24:0] RST_VAL = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== RST_VAL) begin
        errors++;
        report("async_reset", k, obs(k), RST_VAL);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    // Long enough for several small frames and a full 800-pixel line.
    repeat (3500) @(posedge clk);
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1 chk_reset();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1 reset = 1'b0;
      repeat ($urandom_range(300, 2000)) @(posedge clk);
    end
    repeat (4) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sincronizador.md
# vga_sincronizador

Generates 640x480 @ 60 Hz VGA timing for the Batalha Naval display path. It produces the `linha`/`coluna` coordinates and the `areaAtiva` gate consumed by every ship and grid renderer. It also drives the monitor's `hsync`/`vsync` pins and a per-frame strobe for game-state sampling. It divides the system clock down to the pixel rate internally, so all consumers run on `clk`.

## Interface
- `DIV`, 2, `clk` cycles per pixel (50 MHz `clk` → 25 MHz pixel); legal range 1..15
- `H_VIS`, 640, visible columns
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `clk` in 1: system clock; the block's only clock
- `reset` in 1: asynchronous, active-high
- `coluna` out 10: horizontal pixel counter, 0..H_TOT-1 (H_TOT = 800)
- `linha` out 10: vertical line counter, 0..V_TOT-1 (V_TOT = 525)
- `areaAtiva` out 1: high iff `coluna` < H_VIS and `linha` < V_VIS
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `pixelTick` out 1: one-`clk` pulse marking the cycles on which the counters advance
- `inicioQuadro` out 1: one-`clk` pulse on the cycle the counters become (0,0)

## Operation
- The divider counter `div_cnt` counts 0..DIV-1. `tick` = (`div_cnt` == DIV-1). When DIV = 1, `tick` is constantly 1.
- On `tick`, `coluna` increments. At H_TOT-1, `coluna` wraps to 0 and `linha` increments. At V_TOT-1 with `coluna` also at H_TOT-1, `linha` wraps to 0.
- `hsync` = 0 iff `coluna` is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
- `vsync` = 0 iff `linha` is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490, 491].
- `hsync`, `vsync` and `areaAtiva` are registers. Each is loaded on `tick` with the value decoded from the *next* counter value, so they are always cycle-aligned with `linha`/`coluna` and never glitch.
- `inicioQuadro` is registered. It is high for exactly the one `clk` cycle following the `tick` that wrapped (799,524) → (0,0).
- `pixelTick` is a registered copy of `tick`. It is high on the first `clk` of each new counter value.
- Reset values:
  - `div_cnt` = 0
  - `coluna` = 0, `linha` = 0
  - `hsync` = 1, `vsync` = 1
  - `areaAtiva` = 1, since (0,0) is visible
  - `pixelTick` = 0, `inicioQuadro` = 0
- Reset asserted mid-frame forces all of the above immediately, with no wait for `clk`. After deassertion, the first `tick` occurs DIV `clk` edges later and moves `coluna` 0 → 1. No `inicioQuadro` is emitted for the reset-induced (0,0).

## Timing
- Counter latency: one `clk` from `tick` to the updated `coluna`/`linha`/sync outputs. All outputs change on the same edge.
- Line period: 800 ticks = 800·DIV `clk`. Frame period: 525 lines = 420000 ticks.
- Every counter value is held for exactly DIV `clk` cycles.
- Counter arithmetic is 10-bit unsigned. Comparisons use constants widened to 10 bits. H_TOT-1 = 799 and V_TOT-1 = 524 both fit.

## Structure
- Shared package `vga_pkg` holds:
  - the H/V visible, porch and sync constants
  - the derived H_TOT, V_TOT, sync-start and sync-end values
  - the 10-bit coordinate width
- All renderers use the same package so that coordinate math agrees.
- One sub-module, `vga_contador_eixo`, is instantiated twice (horizontal and vertical):
  - Parameters: TOTAL, VIS, SYNC_INI, SYNC_FIM.
  - Inputs: `clk`, `reset`, `en`. Outputs: count, `wrap` (carry out), `sync_n`, `ativo`.
  - The vertical instance's `en` = horizontal `wrap` AND `tick`.
- The divider and the `inicioQuadro`/`pixelTick` registers live in the top module.

## Test plan
- Reset with DIV=2, then hold reset high → `coluna`=0, `linha`=0, `hsync`=1, `vsync`=1, `areaAtiva`=1, `inicioQuadro`=0.
- Release reset → `coluna` reads 1 after exactly 2 `clk` edges. `pixelTick` pulses every 2nd `clk`.
- Run one line → `areaAtiva` falls when `coluna` goes 639 → 640. `hsync` is low for exactly 96 ticks, covering `coluna` 656..751. At 799 → 0, `linha` goes 0 → 1.
- Run one full frame → `vsync` is low only while `linha` is 490 or 491, i.e. 1600 ticks. At (799,524) → (0,0), `inicioQuadro` pulses for 1 `clk`. Consecutive `inicioQuadro` pulses are 840000 `clk` apart.
- Assert `reset` asynchronously mid-`clk` at (300,200) → outputs take their reset values before the next edge. The next frame start yields `inicioQuadro` 420000 ticks after release.
- DIV=1 build → `coluna` advances every `clk`, and the frame is 420000 `clk` long.
